// File: rtl/deskew_ctrl_if.sv
// ============================================================================
// Module      : deskew_ctrl_if
// Description : Status/control bundle between the lane deskew FSM, the
//               per-lane alignment-marker lock logic and deskew_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface deskew_ctrl_if #(
  parameter int N_LANES  = 20,
  parameter int NB_RETRY = 3,
  parameter int NB_EVT   = 8
);
  logic                i_enable;
  logic [N_LANES-1:0]  i_am_lock;
  logic                i_deskew_done;
  logic                i_invalid_skew;
  logic                i_clear_fail;
  logic                o_resync;
  logic                o_align_status;
  logic                o_deskew_fail;
  logic [NB_RETRY-1:0] o_retry_count;
  logic [NB_EVT-1:0]   o_realign_count;
  logic [2:0]          o_state;

  // Side that drives lock/deskew status into the controller
  modport master (
    output i_enable, i_am_lock, i_deskew_done, i_invalid_skew, i_clear_fail,
    input  o_resync, o_align_status, o_deskew_fail, o_retry_count,
           o_realign_count, o_state
  );

  // Controller side
  modport slave (
    input  i_enable, i_am_lock, i_deskew_done, i_invalid_skew, i_clear_fail,
    output o_resync, o_align_status, o_deskew_fail, o_retry_count,
           o_realign_count, o_state
  );
endinterface

`default_nettype wire

// File: rtl/deskew_ctrl.sv
// ============================================================================
// Module      : deskew_ctrl
// Description : Supervisory controller for the 100GbE PCS lane deskew FSM.
//               Waits for all-lane AM lock, pulses resync, supervises deskew
//               completion/timeout/invalid skew with bounded retries, and
//               reports alignment status, sticky failure and event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deskew_ctrl #(
  parameter int N_LANES       = 20,
  parameter int ALIGN_TIMEOUT = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int HOLDOFF       = 256,
  parameter int NB_TIMER      = 16,
  parameter int NB_RETRY      = 3,
  parameter int NB_EVT        = 8
) (
  input  logic          i_clock,
  input  logic          i_reset,
  deskew_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    RESYNC     = 3'd1,
    WAIT_ALIGN = 3'd2,
    ALIGNED    = 3'd3,
    FAILED     = 3'd4
  } state_t;

  localparam logic [NB_TIMER-1:0] TIMEOUT_LAST = NB_TIMER'(ALIGN_TIMEOUT - 1);
  localparam logic [NB_TIMER-1:0] HOLDOFF_LAST = NB_TIMER'(HOLDOFF - 1);
  localparam logic [NB_RETRY-1:0] RETRY_LAST   = NB_RETRY'(MAX_RETRIES - 1);
  localparam logic [NB_EVT-1:0]   EVT_MAX      = '1;
  localparam logic [NB_TIMER-1:0] TIMER_ONE    = NB_TIMER'(1);
  localparam logic [NB_RETRY-1:0] RETRY_ONE    = NB_RETRY'(1);
  localparam logic [NB_EVT-1:0]   EVT_ONE      = NB_EVT'(1);

  state_t              state, state_d;
  logic [NB_TIMER-1:0] timer, timer_d;
  logic [NB_RETRY-1:0] retry, retry_d;
  logic [NB_EVT-1:0]   realign, realign_d;
  logic                fail, fail_d;

  logic [N_LANES-1:0]  lock;
  logic                all_lock;

  assign lock     = bus.i_am_lock;
  assign all_lock = &lock;

  // State and counter registers; frozen while the clock-enable is low
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state   <= WAIT_LOCK;
      timer   <= '0;
      retry   <= '0;
      realign <= '0;
      fail    <= 1'b0;
    end else if (bus.i_enable) begin
      state   <= state_d;
      timer   <= timer_d;
      retry   <= retry_d;
      realign <= realign_d;
      fail    <= fail_d;
    end
  end

  // Next-state logic; a clear request is applied first so that a
  // simultaneous entry to FAILED can override it, while a simultaneous
  // realign event is suppressed and leaves the counter at zero
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    retry_d   = retry;
    realign_d = bus.i_clear_fail ? '0 : realign;
    fail_d    = bus.i_clear_fail ? 1'b0 : fail;

    case (state)
      WAIT_LOCK: begin
        if (all_lock) state_d = RESYNC;
      end

      RESYNC: begin
        timer_d = '0;
        state_d = WAIT_ALIGN;
      end

      WAIT_ALIGN: begin
        timer_d = timer + TIMER_ONE;
        if (!all_lock) begin
          state_d = WAIT_LOCK;
          retry_d = '0;
        end else if (bus.i_deskew_done) begin
          state_d = ALIGNED;
          retry_d = '0;
        end else if (bus.i_invalid_skew || (timer == TIMEOUT_LAST)) begin
          if (retry == RETRY_LAST) begin
            state_d = FAILED;
            fail_d  = 1'b1;
            timer_d = '0;
          end else begin
            retry_d = retry + RETRY_ONE;
            state_d = RESYNC;
          end
        end
      end

      ALIGNED: begin
        if (!all_lock || !bus.i_deskew_done) begin
          state_d = WAIT_LOCK;
          if (!bus.i_clear_fail && (realign != EVT_MAX)) begin
            realign_d = realign + EVT_ONE;
          end
        end
      end

      FAILED: begin
        timer_d = timer + TIMER_ONE;
        if (timer == HOLDOFF_LAST) begin
          retry_d = '0;
          state_d = WAIT_LOCK;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        timer_d = '0;
        retry_d = '0;
      end
    endcase
  end

  assign bus.o_resync        = (state == RESYNC) & bus.i_enable;
  assign bus.o_align_status  = (state == ALIGNED);
  assign bus.o_deskew_fail   = fail;
  assign bus.o_retry_count   = retry;
  assign bus.o_realign_count = realign;
  assign bus.o_state         = state;

endmodule

`default_nettype wire

// File: tb/tb_deskew_ctrl.sv
// ============================================================================
// Module      : tb_deskew_ctrl
// Description : Self-checking bench for deskew_ctrl. Stimulus pushes the
//               expected outputs for the current cycle into a scoreboard;
//               a falling-edge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deskew_ctrl;

  logic clk;
  logic rst_n;

  deskew_ctrl_if #(.N_LANES(20), .NB_RETRY(3), .NB_EVT(8)) bus ();

  deskew_ctrl #(
    .N_LANES(20), .ALIGN_TIMEOUT(1024), .MAX_RETRIES(4), .HOLDOFF(256),
    .NB_TIMER(16), .NB_RETRY(3), .NB_EVT(8)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       rs;
    logic       al;
    logic       fl;
    logic [2:0] rc;
    logic [7:0] ev;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_ev   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end else begin
      n_pass++;
    end
  endtask

  function automatic void push(input string tag, input int st, input int rs,
                               input int al, input int fl, input int rc, input int ev);
    exp_t x;
    x.tag = tag;
    x.st  = 3'(st);
    x.rs  = 1'(rs);
    x.al  = 1'(al);
    x.fl  = 1'(fl);
    x.rc  = 3'(rc);
    x.ev  = 8'(ev);
    sb.push_back(x);
  endfunction

  // Compare every pending expectation against the outputs mid-cycle
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".state"},   32'(bus.o_state),         32'(e.st));
      check({e.tag, ".resync"},  32'(bus.o_resync),        32'(e.rs));
      check({e.tag, ".align"},   32'(bus.o_align_status),  32'(e.al));
      check({e.tag, ".fail"},    32'(bus.o_deskew_fail),   32'(e.fl));
      check({e.tag, ".retry"},   32'(bus.o_retry_count),   32'(e.rc));
      check({e.tag, ".realign"}, 32'(bus.o_realign_count), 32'(e.ev));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full lock -> resync -> align -> lane-7 drop round trip from WAIT_LOCK
  task automatic realign_once(input bit clr_at_exit);
    tick(); push("ro_resync", 1, 1, 0, 0, 0, exp_ev);
    tick(); push("ro_wait",   2, 0, 0, 0, 0, exp_ev);
    tick(); push("ro_align",  3, 0, 1, 0, 0, exp_ev);
    bus.i_am_lock[7]  = 1'b0;
    bus.i_clear_fail  = clr_at_exit;
    tick();
    if (clr_at_exit)       exp_ev = 0;
    else if (exp_ev < 255) exp_ev = exp_ev + 1;
    push("ro_drop", 0, 0, 0, 0, 0, exp_ev);
    bus.i_am_lock[7]  = 1'b1;
    bus.i_clear_fail  = 1'b0;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.i_enable       = 1'b1;
    bus.i_am_lock      = '0;
    bus.i_deskew_done  = 1'b0;
    bus.i_invalid_skew = 1'b0;
    bus.i_clear_fail   = 1'b0;

    // Reset and first alignment
    tick(); tick(); push("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(); push("idle", 0, 0, 0, 0, 0, 0);
    bus.i_am_lock = '1;
    tick(); push("first_resync", 1, 1, 0, 0, 0, 0);
    tick(); push("wa0", 2, 0, 0, 0, 0, 0);
    tick(); push("wa1", 2, 0, 0, 0, 0, 0);
    bus.i_deskew_done = 1'b1;
    tick(); push("aligned", 3, 0, 1, 0, 0, 0);
    tick(); push("aligned_hold", 3, 0, 1, 0, 0, 0);

    // Lane 7 lock loss while aligned, then saturate the realign counter
    bus.i_am_lock[7] = 1'b0;
    tick(); exp_ev = 1; push("lane7_drop", 0, 0, 0, 0, 0, exp_ev);
    bus.i_am_lock[7] = 1'b1;
    for (int i = 0; i < 299; i++) realign_once(1'b0);
    push("saturated", 0, 0, 0, 0, 0, 255);
    tick(); // now RESYNC again via lock
    tick(); tick();
    bus.i_am_lock[7] = 1'b0;
    bus.i_clear_fail = 1'b1;
    tick(); exp_ev = 0; push("clear_vs_incr", 0, 0, 0, 0, 0, 0);
    bus.i_am_lock[7] = 1'b1;
    bus.i_clear_fail = 1'b0;
    realign_once(1'b0);
    bus.i_clear_fail = 1'b1;
    tick(); exp_ev = 0; push("clear_alone", 1, 1, 0, 0, 0, 0);
    bus.i_clear_fail = 1'b0;

    // Lock loss and done in the same WAIT_ALIGN cycle
    tick(); push("wa_pre_conflict", 2, 0, 0, 0, 0, 0);
    bus.i_am_lock[7] = 1'b0;
    tick(); push("lockloss_vs_done", 0, 0, 0, 0, 0, 0);
    bus.i_am_lock[7]  = 1'b1;
    bus.i_deskew_done = 1'b0;

    // Four invalid-skew aborts
    tick(); push("inv_resync0", 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(); push("inv_wait", 2, 0, 0, 0, k - 1, 0);
      bus.i_invalid_skew = 1'b1;
      tick();
      bus.i_invalid_skew = 1'b0;
      if (k < 4) push("inv_retry", 1, 1, 0, 0, k, 0);
      else       push("inv_failed", 4, 0, 0, 1, 3, 0);
    end
    bus.i_invalid_skew = 1'b1;
    for (int j = 1; j <= 255; j++) begin
      tick();
      bus.i_invalid_skew = 1'b0;
      if (j == 1 || j == 255) push("holdoff", 4, 0, 0, 1, 3, 0);
    end
    tick(); push("holdoff_exit", 0, 0, 0, 1, 0, 0);

    // Timeout retries; clear early, then clear coinciding with FAILED entry
    tick(); push("to_resync0", 1, 1, 0, 1, 0, 0);
    bus.i_clear_fail = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      tick();
      bus.i_clear_fail = 1'b0;
      push("to_wait_first", 2, 0, 0, 0, a - 1, 0);
      for (int j = 2; j <= 1024; j++) begin
        tick();
        if (j == 1024) push("to_wait_last", 2, 0, 0, 0, a - 1, 0);
      end
      if (a == 4) bus.i_clear_fail = 1'b1;
      tick();
      bus.i_clear_fail = 1'b0;
      if (a < 4) push("to_retry", 1, 1, 0, 0, a, 0);
      else       push("to_failed_set_wins", 4, 0, 0, 1, 3, 0);
    end
    for (int j = 1; j <= 255; j++) tick();
    tick(); push("to_holdoff_exit", 0, 0, 0, 1, 0, 0);

    // Clock-enable gating during RESYNC
    tick();
    bus.i_enable       = 1'b0;
    bus.i_invalid_skew = 1'b1;
    bus.i_clear_fail   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push("resync_gated", 1, 0, 0, 1, 0, 0);
      tick();
    end
    bus.i_enable       = 1'b1;
    bus.i_invalid_skew = 1'b0;
    bus.i_clear_fail   = 1'b0;
    push("resync_reenabled", 1, 1, 0, 1, 0, 0);
    tick(); push("en_wait", 2, 0, 0, 1, 0, 0);
    bus.i_deskew_done = 1'b1;
    tick(); push("en_aligned", 3, 0, 1, 1, 0, 0);

    // Reset while aligned
    rst_n = 1'b0;
    tick(); push("mid_reset", 0, 0, 0, 0, 0, 0);
    tick(); push("reset_held", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(); push("post_reset_resync", 1, 1, 0, 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
